// File: rtl/pms_shell_pkg.sv
// Shared constants, bus types and helpers for the PMS boot/doorbell control shell.
package pms_shell_pkg;

  localparam logic [31:0] MBOX_BASE   = 32'h2000_0000;
  localparam logic [31:0] CSR_BASE    = 32'h1A10_4000;
  localparam logic [31:0] CSR_SIZE    = 32'h0000_1000;
  localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;

  localparam logic [11:0] CSR_BOOTMODE  = 12'h000;
  localparam logic [11:0] CSR_BOOT_ADDR = 12'h004;
  localparam logic [11:0] CSR_FETCH_EN  = 12'h008;
  localparam logic [11:0] CSR_STATUS    = 12'h00C;
  localparam logic [11:0] CSR_IRQ_EN    = 12'h020;
  localparam logic [11:0] CSR_IRQ_PEND  = 12'h040;
  localparam logic [11:0] CSR_IRQ_ID    = 12'h060;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_MBOX,
    TGT_CSR
  } target_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } bus_rsp_t;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    return (old_val & ~be_mask(be)) | (wdata & be_mask(be));
  endfunction

  // Misaligned mailbox addresses fall through to a decode error.
  function automatic target_e decode_target(input logic [31:0] addr,
                                            input logic [31:0] mbox_base,
                                            input logic [31:0] mbox_bytes,
                                            input logic [31:0] csr_base);
    logic [31:0] mbox_off;
    logic [31:0] csr_off;
    mbox_off = addr - mbox_base;
    csr_off  = addr - csr_base;
    if (mbox_off < mbox_bytes && mbox_off[1:0] == 2'b00) return TGT_MBOX;
    if (csr_off < CSR_SIZE) return TGT_CSR;
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/pms_doorbell_shell_if.sv
// Request/grant bus with one-cycle response, shared by the host and core ports.
interface pms_doorbell_shell_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/pms_db_irq_ctrl.sv
// Doorbell collector: rising-edge capture into pending, per-line enable, W1C and
// lowest-index priority encoder.
module pms_db_irq_ctrl
  import pms_shell_pkg::*;
#(
  parameter int unsigned NumIrq = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumIrq-1:0] db_irq,
  input  logic [2:0]        word,
  input  logic              en_wr,
  input  logic [31:0]       en_wdata,
  input  logic              pend_clr,
  input  logic [31:0]       clr_mask,
  output logic [31:0]       en_rdata,
  output logic [31:0]       pend_rdata,
  output logic              irq,
  output logic [7:0]        irq_id
);

  localparam int unsigned NumWords = NumIrq / 32;

  logic [NumIrq-1:0] db_q;
  logic [NumIrq-1:0] en_q;
  logic [NumIrq-1:0] pend_q;
  logic [NumIrq-1:0] en_d;
  logic [NumIrq-1:0] clr;
  logic [NumIrq-1:0] active;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    en_d       = en_q;
    clr        = '0;
    en_rdata   = '0;
    pend_rdata = '0;
    for (int k = 0; k < NumWords; k++) begin
      if (word == 3'(k)) begin
        en_rdata   = en_q[32*k +: 32];
        pend_rdata = pend_q[32*k +: 32];
        if (en_wr)    en_d[32*k +: 32] = en_wdata;
        if (pend_clr) clr[32*k +: 32]  = clr_mask;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q   <= '0;
      en_q   <= '0;
      pend_q <= '0;
    end else begin
      db_q   <= db_irq;
      en_q   <= en_d;
      // The set term is ORed in after the clear so a coincident edge is never lost.
      pend_q <= (pend_q & ~clr) | (db_irq & ~db_q);
    end
  end

  assign active = pend_q & en_q;
  assign irq    = |active;

  always_comb begin
    irq_id = '0;
    for (int i = NumIrq - 1; i >= 0; i--) begin
      if (active[i]) irq_id = 8'(i);
    end
  end

endmodule

// File: rtl/pms_doorbell_shell.sv
// PMS control shell: boot CSRs, shared mailbox SRAM and doorbell collector behind
// a host-priority two-port arbiter.
module pms_doorbell_shell
  import pms_shell_pkg::*;
#(
  parameter int unsigned MboxWords = 256,
  parameter logic [31:0] MboxBase  = MBOX_BASE,
  parameter logic [31:0] CsrBase   = CSR_BASE,
  parameter int unsigned NumIrq    = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pms_doorbell_shell_if.slave  host,
  pms_doorbell_shell_if.slave  core,
  input  logic [NumIrq-1:0]    db_irq_i,
  output logic [1:0]           bootmode_o,
  output logic [31:0]          boot_addr_o,
  output logic                 fetch_en_o,
  output logic                 eoc_o,
  output logic                 irq_o,
  output logic [7:0]           irq_id_o
);

  localparam int unsigned MboxAw    = $clog2(MboxWords);
  localparam logic [31:0] MboxBytes = 32'(MboxWords * 4);
  localparam int unsigned NumWords  = NumIrq / 32;

  bus_req_t host_req, core_req;
  target_e  host_tgt, core_tgt;
  logic     host_gnt, core_gnt;
  logic     host_mbox, core_mbox, host_csr, core_csr;

  assign host_req = '{req: host.req, we: host.we, addr: host.addr, wdata: host.wdata, be: host.be};
  assign core_req = '{req: core.req, we: core.we, addr: core.addr, wdata: core.wdata, be: core.be};

  assign host_tgt = decode_target(host_req.addr, MboxBase, MboxBytes, CsrBase);
  assign core_tgt = decode_target(core_req.addr, MboxBase, MboxBytes, CsrBase);

  // No grants while reset is asserted, so nothing is written once rst_ni falls.
  assign host_gnt = rst_ni && host_req.req;
  assign core_gnt = rst_ni && core_req.req &&
                    !(host_req.req && host_tgt == core_tgt && core_tgt != TGT_NONE);

  assign host_mbox = host_gnt && host_tgt == TGT_MBOX;
  assign core_mbox = core_gnt && core_tgt == TGT_MBOX;
  assign host_csr  = host_gnt && host_tgt == TGT_CSR;
  assign core_csr  = core_gnt && core_tgt == TGT_CSR;

  // Mailbox. The base is aligned to the window size, so the word index is a plain slice.
  logic              mbox_en, mbox_we;
  logic [MboxAw-1:0] mbox_idx;
  logic [31:0]       mbox_wdata;
  logic [3:0]        mbox_be;
  logic [31:0]       mbox_mem [MboxWords];
  logic [31:0]       mbox_rdata_q;

  assign mbox_en    = host_mbox || core_mbox;
  assign mbox_we    = host_mbox ? host_req.we    : core_req.we;
  assign mbox_idx   = host_mbox ? host_req.addr[2 +: MboxAw] : core_req.addr[2 +: MboxAw];
  assign mbox_wdata = host_mbox ? host_req.wdata : core_req.wdata;
  assign mbox_be    = host_mbox ? host_req.be    : core_req.be;

  // NOTE: the mailbox array has no reset so it can map onto a single-port SRAM.
  always_ff @(posedge clk_i) begin
    if (mbox_en) begin
      if (mbox_we) mbox_mem[mbox_idx] <= be_merge(mbox_mem[mbox_idx], mbox_wdata, mbox_be);
      mbox_rdata_q <= mbox_mem[mbox_idx];
    end
  end

  // CSR block: at most one port owns it per cycle.
  logic        csr_en, csr_we, csr_from_core;
  logic [11:0] csr_off;
  logic [31:0] csr_wdata, csr_rdata, csr_merged;
  logic [3:0]  csr_be;
  logic        csr_err;
  logic [31:0] csr_rdata_q;
  logic        csr_err_q;
  logic [1:0]  bootmode_q;
  logic [31:0] boot_addr_q;
  logic        fetch_en_q, eoc_q;
  logic [30:0] exit_code_q;
  logic [2:0]  irq_word;
  logic        irq_word_ok, irq_en_wr, irq_pend_clr;
  logic [31:0] irq_en_rdata, irq_pend_rdata;

  assign csr_en        = host_csr || core_csr;
  assign csr_from_core = core_csr;
  assign csr_we        = host_csr ? host_req.we    : core_req.we;
  assign csr_off       = host_csr ? host_req.addr[11:0] : core_req.addr[11:0];
  assign csr_wdata     = host_csr ? host_req.wdata : core_req.wdata;
  assign csr_be        = host_csr ? host_req.be    : core_req.be;
  assign csr_merged    = be_merge(csr_rdata, csr_wdata, csr_be);

  assign irq_word    = csr_off[4:2];
  assign irq_word_ok = csr_off[1:0] == 2'b00 && 32'(irq_word) < NumWords;

  always_comb begin
    csr_rdata    = DECERR_DATA;
    csr_err      = 1'b0;
    irq_en_wr    = 1'b0;
    irq_pend_clr = 1'b0;
    if (csr_off[11:5] == CSR_IRQ_EN[11:5] && irq_word_ok) begin
      csr_rdata = irq_en_rdata;
      irq_en_wr = csr_en && csr_we;
    end else if (csr_off[11:5] == CSR_IRQ_PEND[11:5] && irq_word_ok) begin
      csr_rdata    = irq_pend_rdata;
      irq_pend_clr = csr_en && csr_we;
    end else begin
      case (csr_off)
        CSR_BOOTMODE:  csr_rdata = {30'b0, bootmode_q};
        CSR_BOOT_ADDR: csr_rdata = boot_addr_q;
        CSR_FETCH_EN:  csr_rdata = {31'b0, fetch_en_q};
        CSR_STATUS: begin
          csr_rdata = {eoc_q, exit_code_q};
          csr_err   = csr_we && !csr_from_core;
        end
        CSR_IRQ_ID:    csr_rdata = {23'b0, irq_o, irq_id_o};
        default:       csr_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bootmode_q  <= '0;
      boot_addr_q <= '0;
      fetch_en_q  <= 1'b0;
      eoc_q       <= 1'b0;
      exit_code_q <= '0;
      csr_rdata_q <= '0;
      csr_err_q   <= 1'b0;
    end else begin
      if (csr_en) begin
        csr_rdata_q <= csr_rdata;
        csr_err_q   <= csr_err;
      end
      if (csr_en && csr_we && !csr_err) begin
        case (csr_off)
          CSR_BOOTMODE:  bootmode_q  <= csr_merged[1:0];
          CSR_BOOT_ADDR: boot_addr_q <= csr_merged;
          CSR_FETCH_EN:  fetch_en_q  <= csr_merged[0];
          CSR_STATUS: begin
            eoc_q       <= 1'b1;
            exit_code_q <= csr_merged[30:0];
          end
          default: ;
        endcase
      end
    end
  end

  pms_db_irq_ctrl #(.NumIrq(NumIrq)) u_irq (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .db_irq     (db_irq_i),
    .word       (irq_word),
    .en_wr      (irq_en_wr),
    .en_wdata   (csr_merged),
    .pend_clr   (irq_pend_clr),
    .clr_mask   (csr_wdata & be_mask(csr_be)),
    .en_rdata   (irq_en_rdata),
    .pend_rdata (irq_pend_rdata),
    .irq        (irq_o),
    .irq_id     (irq_id_o)
  );

  // Per-port response tracking: which target served the access granted last cycle.
  logic    host_rvalid_q, core_rvalid_q;
  target_e host_src_q, core_src_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_rvalid_q <= 1'b0;
      core_rvalid_q <= 1'b0;
      host_src_q    <= TGT_NONE;
      core_src_q    <= TGT_NONE;
    end else begin
      host_rvalid_q <= host_gnt;
      core_rvalid_q <= core_gnt;
      if (host_gnt) host_src_q <= host_tgt;
      if (core_gnt) core_src_q <= core_tgt;
    end
  end

  function automatic bus_rsp_t make_rsp(input logic gnt, input logic rvalid, input target_e src,
                                        input logic csr_err_r, input logic [31:0] mbox_rd,
                                        input logic [31:0] csr_rd);
    bus_rsp_t rsp;
    rsp.gnt    = gnt;
    rsp.rvalid = rvalid;
    rsp.err    = rvalid && (src == TGT_NONE || (src == TGT_CSR && csr_err_r));
    if (!rvalid)             rsp.rdata = '0;
    else if (rsp.err)        rsp.rdata = DECERR_DATA;
    else if (src == TGT_MBOX) rsp.rdata = mbox_rd;
    else                     rsp.rdata = csr_rd;
    return rsp;
  endfunction

  bus_rsp_t host_rsp, core_rsp;

  assign host_rsp = make_rsp(host_gnt, host_rvalid_q, host_src_q, csr_err_q, mbox_rdata_q, csr_rdata_q);
  assign core_rsp = make_rsp(core_gnt, core_rvalid_q, core_src_q, csr_err_q, mbox_rdata_q, csr_rdata_q);

  assign host.gnt    = host_rsp.gnt;
  assign host.rvalid = host_rsp.rvalid;
  assign host.rdata  = host_rsp.rdata;
  assign host.err    = host_rsp.err;
  assign core.gnt    = core_rsp.gnt;
  assign core.rvalid = core_rsp.rvalid;
  assign core.rdata  = core_rsp.rdata;
  assign core.err    = core_rsp.err;

  assign bootmode_o  = bootmode_q;
  assign boot_addr_o = boot_addr_q;
  assign fetch_en_o  = fetch_en_q;
  assign eoc_o       = eoc_q;

endmodule

// File: tb/tb_pms_doorbell_shell.sv
// Directed self-checking bench for pms_doorbell_shell: boot CSRs, mailbox,
// doorbells, arbitration, decode errors, EOC and reset during an access.
module tb_pms_doorbell_shell;

  localparam logic [31:0] CSR  = 32'h1A10_4000;
  localparam logic [31:0] MBOX = 32'h2000_0000;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [255:0] db_irq = '0;
  logic [1:0]   bootmode;
  logic [31:0]  boot_addr;
  logic         fetch_en, eoc, irq;
  logic [7:0]   irq_id;

  int checks   = 0;
  int failures = 0;

  pms_doorbell_shell_if host_bus ();
  pms_doorbell_shell_if core_bus ();

  pms_doorbell_shell dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .host        (host_bus),
    .core        (core_bus),
    .db_irq_i    (db_irq),
    .bootmode_o  (bootmode),
    .boot_addr_o (boot_addr),
    .fetch_en_o  (fetch_en),
    .eoc_o       (eoc),
    .irq_o       (irq),
    .irq_id_o    (irq_id)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit is_core, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    if (is_core) begin
      core_bus.req = req; core_bus.we = we; core_bus.addr = addr;
      core_bus.wdata = wdata; core_bus.be = be;
    end else begin
      host_bus.req = req; host_bus.we = we; host_bus.addr = addr;
      host_bus.wdata = wdata; host_bus.be = be;
    end
  endtask

  // Called at a negedge; returns at the following negedge after the response.
  task automatic xfer(input bit is_core, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] rdata, output logic err);
    int   waited = 0;
    logic gnt, rvalid;
    drive(is_core, 1'b1, we, addr, wdata, be);
    #1;
    gnt = is_core ? core_bus.gnt : host_bus.gnt;
    while (!gnt && waited < 16) begin
      @(negedge clk_i); #1;
      gnt = is_core ? core_bus.gnt : host_bus.gnt;
      waited++;
    end
    check(is_core ? "core_gnt" : "host_gnt", {31'b0, gnt}, 32'd1);
    @(posedge clk_i); #1;
    drive(is_core, 1'b0, 1'b0, '0, '0, '0);
    rvalid = is_core ? core_bus.rvalid : host_bus.rvalid;
    rdata  = is_core ? core_bus.rdata  : host_bus.rdata;
    err    = is_core ? core_bus.err    : host_bus.err;
    check(is_core ? "core_rvalid" : "host_rvalid", {31'b0, rvalid}, 32'd1);
    @(negedge clk_i);
  endtask

  task automatic wr(input string tag, input bit is_core, input logic [31:0] addr,
                    input logic [31:0] data, input logic [3:0] be, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    xfer(is_core, 1'b1, addr, data, be, rd, er);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  task automatic rd(input string tag, input bit is_core, input logic [31:0] addr,
                    input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] d;
    logic        er;
    xfer(is_core, 1'b0, addr, '0, 4'h0, d, er);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk_i);

    // Reset state
    check("rst_bootmode", {30'b0, bootmode}, 32'd0);
    check("rst_boot_addr", boot_addr, 32'd0);
    check("rst_fetch_en", {31'b0, fetch_en}, 32'd0);
    check("rst_eoc", {31'b0, eoc}, 32'd0);
    check("rst_irq", {23'b0, irq, irq_id}, 32'd0);
    check("rst_rvalid", {30'b0, host_bus.rvalid, core_bus.rvalid}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Boot sequence
    wr("boot_mode_wr", 1'b0, CSR + 32'h00, 32'd3, 4'hF, 1'b0);
    wr("boot_addr_wr", 1'b0, CSR + 32'h04, 32'h1C00_8080, 4'hF, 1'b0);
    wr("boot_fetch_wr", 1'b0, CSR + 32'h08, 32'd1, 4'hF, 1'b0);
    check("bootmode_o", {30'b0, bootmode}, 32'd3);
    check("boot_addr_o", boot_addr, 32'h1C00_8080);
    check("fetch_en_o", {31'b0, fetch_en}, 32'd1);
    rd("boot_mode_rd", 1'b0, CSR + 32'h00, 32'd3, 1'b0);
    rd("boot_addr_rd", 1'b0, CSR + 32'h04, 32'h1C00_8080, 1'b0);
    rd("boot_fetch_rd", 1'b0, CSR + 32'h08, 32'd1, 1'b0);

    // Mailbox notifier and byte enables
    wr("mb_host0", 1'b0, MBOX, 32'd0, 4'hF, 1'b0);
    wr("mb_core1", 1'b1, MBOX, 32'd1, 4'hF, 1'b0);
    rd("mb_poll", 1'b0, MBOX, 32'd1, 1'b0);
    wr("mb_clr4", 1'b0, MBOX + 32'h4, 32'd0, 4'hF, 1'b0);
    wr("mb_be", 1'b0, MBOX + 32'h4, 32'hAABB_CCDD, 4'b0010, 1'b0);
    rd("mb_be_rd", 1'b1, MBOX + 32'h4, 32'h0000_CC00, 1'b0);

    // Same-target arbitration: host first, core one cycle later
    wr("arb_set_a", 1'b0, MBOX + 32'h10, 32'h1111_2222, 4'hF, 1'b0);
    wr("arb_set_b", 1'b0, MBOX + 32'h14, 32'h3333_4444, 4'hF, 1'b0);
    drive(1'b0, 1'b1, 1'b0, MBOX + 32'h10, '0, '0);
    drive(1'b1, 1'b1, 1'b0, MBOX + 32'h14, '0, '0);
    #1;
    check("arb_host_gnt", {31'b0, host_bus.gnt}, 32'd1);
    check("arb_core_stall", {31'b0, core_bus.gnt}, 32'd0);
    @(posedge clk_i); #1;
    check("arb_host_rvalid", {31'b0, host_bus.rvalid}, 32'd1);
    check("arb_host_rdata", host_bus.rdata, 32'h1111_2222);
    check("arb_core_no_rvalid", {31'b0, core_bus.rvalid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    check("arb_core_gnt", {31'b0, core_bus.gnt}, 32'd1);
    @(posedge clk_i); #1;
    check("arb_core_rvalid", {31'b0, core_bus.rvalid}, 32'd1);
    check("arb_core_rdata", core_bus.rdata, 32'h3333_4444);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk_i);

    // Different targets are served in parallel
    drive(1'b0, 1'b1, 1'b0, CSR + 32'h04, '0, '0);
    drive(1'b1, 1'b1, 1'b0, MBOX + 32'h10, '0, '0);
    #1;
    check("par_gnt", {30'b0, host_bus.gnt, core_bus.gnt}, 32'd3);
    @(posedge clk_i); #1;
    check("par_host_rdata", host_bus.rdata, 32'h1C00_8080);
    check("par_core_rdata", core_bus.rdata, 32'h1111_2222);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk_i);

    // Concurrent doorbell on all lines
    for (int k = 0; k < 8; k++) wr("irq_en_wr", 1'b0, CSR + 32'h20 + 32'(4 * k), 32'hFFFF_FFFF, 4'hF, 1'b0);
    db_irq = '1;
    @(negedge clk_i);
    db_irq = '0;
    check("db_all_irq", {31'b0, irq}, 32'd1);
    check("db_all_id", {24'b0, irq_id}, 32'd0);
    for (int k = 0; k < 8; k++) rd("db_all_pend", 1'b0, CSR + 32'h40 + 32'(4 * k), 32'hFFFF_FFFF, 1'b0);
    rd("irq_id_csr", 1'b1, CSR + 32'h60, 32'h0000_0100, 1'b0);

    // W1C: bit 0, then words 0..2, then the rest
    wr("w1c_bit0", 1'b0, CSR + 32'h40, 32'h0000_0001, 4'hF, 1'b0);
    check("w1c_bit0_id", {24'b0, irq_id}, 32'd1);
    for (int k = 0; k < 3; k++) wr("w1c_lo", 1'b0, CSR + 32'h40 + 32'(4 * k), 32'hFFFF_FFFF, 4'hF, 1'b0);
    check("w1c_lo_id", {24'b0, irq_id}, 32'd96);
    for (int k = 3; k < 8; k++) wr("w1c_hi", 1'b0, CSR + 32'h40 + 32'(4 * k), 32'hFFFF_FFFF, 4'hF, 1'b0);
    check("w1c_all_irq", {23'b0, irq, irq_id}, 32'd0);

    // Edge on line 5 coincident with W1C of bit 5: set wins
    db_irq[5] = 1'b1;
    @(negedge clk_i);
    db_irq[5] = 1'b0;
    check("l5_id", {24'b0, irq_id}, 32'd5);
    @(negedge clk_i);
    db_irq[5] = 1'b1;
    wr("collide_w1c", 1'b0, CSR + 32'h40, 32'h0000_0020, 4'hF, 1'b0);
    db_irq[5] = 1'b0;
    check("collide_irq", {23'b0, irq, irq_id}, 32'h0000_0105);
    rd("collide_pend", 1'b0, CSR + 32'h40, 32'h0000_0020, 1'b0);

    // Decode errors and EOC
    rd("unmapped_csr", 1'b0, 32'h1A10_4FFC, 32'hDEAD_BEEF, 1'b1);
    rd("outside", 1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 1'b1);
    wr("host_status_wr", 1'b0, CSR + 32'h0C, 32'h8000_0007, 4'hF, 1'b1);
    check("eoc_after_host_wr", {31'b0, eoc}, 32'd0);
    rd("host_status_rd", 1'b0, CSR + 32'h0C, 32'd0, 1'b0);
    wr("core_status_wr", 1'b1, CSR + 32'h0C, 32'd0, 4'hF, 1'b0);
    check("eoc_set", {31'b0, eoc}, 32'd1);
    rd("core_status_rd", 1'b1, CSR + 32'h0C, 32'h8000_0000, 1'b0);

    // Reset falls during a mailbox write: the write must not land
    wr("rst_mb_pre", 1'b0, MBOX + 32'h20, 32'h0BAD_F00D, 4'hF, 1'b0);
    drive(1'b0, 1'b1, 1'b1, MBOX + 32'h20, 32'hFFFF_FFFF, 4'hF);
    #2;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check("rst_mid_rvalid", {31'b0, host_bus.rvalid}, 32'd0);
    check("rst_mid_outputs", {28'b0, bootmode, fetch_en, eoc}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    rd("rst_mb_post", 1'b0, MBOX + 32'h20, 32'h0BAD_F00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
